sync_frame_packer: RTL and testbench

- Sits directly downstream of the 4-cycle sync strobe generator.
- Buffers incoming data words in a small FIFO with a valid/ready handshake.
- On each sync beat, emits exactly one framed word: either the FIFO head, or an idle word when the FIFO is empty.
- Also stamps each emitted word with a wrapping sequence number and keeps a saturating underflow count.

---
 rtl/sync_frame_packer.sv | 112 +++++++++++
 tb/tb_sync_frame_packer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sync_frame_packer.sv
// Small FIFO that emits exactly one framed word (FIFO head or idle word) per sync beat.
// Optional `define SYNC_FRAME_PARITY_EN adds a registered even-parity output out_parity.
module sync_frame_packer #(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 4,
  parameter int                SEQ_W     = 4,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0,
  parameter int                UF_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_in,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_idle,
  output logic [SEQ_W-1:0]  out_seq,
`ifdef SYNC_FRAME_PARITY_EN
  output logic              out_parity,
`endif
  output logic [UF_W-1:0]   underflow_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              sync_prev_reg;
  logic [SEQ_W-1:0]  frame_cnt_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg, out_idle_reg;
  logic [SEQ_W-1:0]  out_seq_reg;
  logic [UF_W-1:0]   underflow_cnt_reg;

  logic full, empty, push, beat, pop;

  // Flags come only from registered occupancy, so in_ready has no input path.
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign push  = in_valid & ~full;
  assign beat  = sync_in & ~sync_prev_reg;
  assign pop   = beat & ~empty;

  // Storage is left unreset; contents are discarded logically by clearing the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_prev_reg     <= 1'b1;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      frame_cnt_reg     <= '0;
      out_data_reg      <= IDLE_WORD;
      out_valid_reg     <= 1'b0;
      out_idle_reg      <= 1'b0;
      out_seq_reg       <= '0;
      underflow_cnt_reg <= '0;
    end else begin
      sync_prev_reg <= sync_in;
      out_valid_reg <= beat;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (beat) begin
        out_seq_reg   <= frame_cnt_reg;
        frame_cnt_reg <= frame_cnt_reg + SEQ_W'(1);
        if (pop) begin
          out_data_reg <= mem[rd_ptr_reg];
          out_idle_reg <= 1'b0;
        end else begin
          out_data_reg <= IDLE_WORD;
          out_idle_reg <= 1'b1;
          if (underflow_cnt_reg != '1)
            underflow_cnt_reg <= underflow_cnt_reg + UF_W'(1);
        end
      end
    end
  end

`ifdef SYNC_FRAME_PARITY_EN
  logic out_parity_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_parity_reg <= 1'b0;
    end else if (beat) begin
      out_parity_reg <= pop ? ^{1'b0, mem[rd_ptr_reg]} : ^{1'b1, IDLE_WORD};
    end
  end

  assign out_parity = out_parity_reg;
`endif

  assign in_ready      = ~full;
  assign out_data      = out_data_reg;
  assign out_valid     = out_valid_reg;
  assign out_idle      = out_idle_reg;
  assign out_seq       = out_seq_reg;
  assign underflow_cnt = underflow_cnt_reg;

endmodule

// File: tb/tb_sync_frame_packer.sv
// Directed self-checking bench for sync_frame_packer (default parameters).
module tb_sync_frame_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync_in;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_idle;
  logic [3:0] out_seq;
  logic [7:0] underflow_cnt;
`ifdef SYNC_FRAME_PARITY_EN
  logic       out_parity;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  sync_frame_packer dut (
    .clk          (clk),
    .rst          (rst),
    .sync_in      (sync_in),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_idle     (out_idle),
    .out_seq      (out_seq),
`ifdef SYNC_FRAME_PARITY_EN
    .out_parity   (out_parity),
`endif
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("[TB] push 0x%02h", d);
  endtask

  task automatic beat_check(input logic exp_idle, input logic [7:0] exp_data,
                            input logic [3:0] exp_seq, input logic [7:0] exp_uf);
    sync_in = 1'b1;
    @(posedge clk); #1;
    sync_in = 1'b0;
    check("beat_valid", 32'(out_valid), 32'd1);
    check("beat_idle",  32'(out_idle),  32'(exp_idle));
    check("beat_data",  32'(out_data),  32'(exp_data));
    check("beat_seq",   32'(out_seq),   32'(exp_seq));
    check("beat_uf",    32'(underflow_cnt), 32'(exp_uf));
`ifdef SYNC_FRAME_PARITY_EN
    check("beat_parity", 32'(out_parity), 32'(^{exp_idle, exp_data}));
`endif
    $display("[TB] frame idle=%0b data=0x%02h seq=%0d uf=%0d", out_idle, out_data, out_seq, underflow_cnt);
    @(posedge clk); #1;
    check("valid_pulse", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; sync_in = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'h00);
    check("rst_idle",  32'(out_idle),  32'd0);
    check("rst_seq",   32'(out_seq),   32'd0);
    check("rst_uf",    32'(underflow_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // sync_in still high from reset: that level must not be a beat.
    @(posedge clk); #1;
    check("no_beat_at_release", 32'(out_valid), 32'd0);
    sync_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("no_beat_low", 32'(out_valid), 32'd0);

    beat_check(1'b1, 8'h00, 4'd0, 8'd1);
    beat_check(1'b1, 8'h00, 4'd1, 8'd2);

    push(8'hA1); push(8'hB2); push(8'hC3);
    beat_check(1'b0, 8'hA1, 4'd2, 8'd2);
    beat_check(1'b0, 8'hB2, 4'd3, 8'd2);
    beat_check(1'b0, 8'hC3, 4'd4, 8'd2);
    beat_check(1'b1, 8'h00, 4'd5, 8'd3);

    // Fill, then hold 0xFF at the input while full.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    in_valid = 1'b1; in_data = 8'hFF;
    check("full_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("full_hold_ready", 32'(in_ready), 32'd0);
    sync_in = 1'b1;
    @(posedge clk); #1;
    sync_in = 1'b0;
    check("pop_full_data", 32'(out_data), 32'h11);
    check("pop_full_seq",  32'(out_seq),  32'd6);
    check("ready_after_pop", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ff_accepted_full", 32'(in_ready), 32'd0);
    $display("[TB] 0xFF accepted after pop");
    @(posedge clk); #1;
    beat_check(1'b0, 8'h22, 4'd7,  8'd3);
    beat_check(1'b0, 8'h33, 4'd8,  8'd3);
    beat_check(1'b0, 8'h44, 4'd9,  8'd3);
    beat_check(1'b0, 8'hFF, 4'd10, 8'd3);
    beat_check(1'b1, 8'h00, 4'd11, 8'd4);

    // Asynchronous reset with a full FIFO and a beat pending.
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    check("pre_rst_ready", 32'(in_ready), 32'd0);
    sync_in = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("async_rst_ready", 32'(in_ready), 32'd1);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_seq",   32'(out_seq), 32'd0);
    check("async_rst_uf",    32'(underflow_cnt), 32'd0);
    $display("[TB] async reset asserted");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst2_no_beat", 32'(out_valid), 32'd0);
    sync_in = 1'b0;
    @(posedge clk); #1;

    // 260 idle beats: seq wraps every 16, underflow saturates at 255.
    for (int i = 0; i < 260; i++) begin
      beat_check(1'b1, 8'h00, 4'(i % 16), 8'((i + 1 > 255) ? 255 : i + 1));
    end
    check("uf_saturated", 32'(underflow_cnt), 32'd255);

    push(8'h07); push(8'h03);
    beat_check(1'b0, 8'h07, 4'd4, 8'd255);
    beat_check(1'b0, 8'h03, 4'd5, 8'd255);
    beat_check(1'b1, 8'h00, 4'd6, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
